bus_host_arbiter: RTL and testbench

Round-robin arbiter that shares the system bus between `NrHosts` masters, replacing fixed lowest-index-wins host selection. It grants one requester per cycle, drives the host-select index the bus mux uses, and tracks the one-cycle-later response so read data and `rvalid` return to the correct host. An optional lock feature lets a host hold the bus for a bounded burst.

---
 rtl/bus_host_arbiter.sv | 87 ++++++++
 tb/tb_bus_host_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bus_host_arbiter.sv
// bus_host_arbiter: round-robin bus arbiter with one-cycle response steering.
// Define BUS_ARB_LOCK_EN to build the bounded lock-burst (LOCKED) feature.
module bus_host_arbiter #(
    parameter int NrHosts = 2,
    parameter int MaxLock = 4,
    parameter int SelW    = (NrHosts > 2) ? $clog2(NrHosts) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrHosts-1:0] host_req_i,
    input  logic [NrHosts-1:0] host_lock_i,
    output logic [NrHosts-1:0] host_gnt_o,
    output logic [SelW-1:0]    host_sel_o,
    output logic               gnt_valid_o,
    output logic [NrHosts-1:0] host_rvalid_o,
    output logic [SelW-1:0]    resp_sel_o,
    output logic               locked_o
);
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t          state, state_d;
    logic [SelW-1:0] last_q, resp_sel_q, win, idx, sel;
    logic            rvalid_q, found, hold, lock_entry, valid;

    // Scan from last_q+1 with an explicit wrap so non-power-of-two counts stay in range.
    always_comb begin
        win   = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int k = 0; k < NrHosts; k++) begin
            idx = (idx == SelW'(NrHosts - 1)) ? '0 : idx + 1'b1;
            if (!found && host_req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef BUS_ARB_LOCK_EN
    logic [7:0] lock_cnt_q;

    assign hold       = (state == LOCKED) && host_req_i[last_q] && host_lock_i[last_q] &&
                        (lock_cnt_q != 8'(MaxLock));
    assign lock_entry = found && (state != IDLE) && host_lock_i[win];
    assign locked_o   = (state == LOCKED);

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) lock_cnt_q <= '0;
        else       lock_cnt_q <= hold ? lock_cnt_q + 8'd1 : lock_entry ? 8'd1 : 8'd0;
`else
    logic unused_lock;

    assign hold        = 1'b0;
    assign lock_entry  = 1'b0;
    assign locked_o    = 1'b0;
    assign unused_lock = ^{host_lock_i, state};
`endif

    // A release cycle out of LOCKED arbitrates exactly like a GRANT cycle.
    assign valid   = hold | found;
    assign sel     = hold ? last_q : win;
    assign state_d = hold ? LOCKED : !found ? IDLE : lock_entry ? LOCKED : GRANT;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state      <= IDLE;
            last_q     <= SelW'(NrHosts - 1);
            resp_sel_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state      <= state_d;
            last_q     <= valid ? sel : last_q;
            resp_sel_q <= sel;
            rvalid_q   <= valid;
        end

    always_comb begin
        host_gnt_o                = '0;
        host_gnt_o[sel]           = valid;
        host_rvalid_o             = '0;
        host_rvalid_o[resp_sel_q] = rvalid_q;
    end

    assign host_sel_o  = sel;
    assign gnt_valid_o = valid;
    assign resp_sel_o  = resp_sel_q;
endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb_bus_host_arbiter: vector tables plus randomized traffic against a cycle-level model.
module tb_bus_host_arbiter;
    localparam int N  = 3;
    localparam int ML = 4;
`ifdef BUS_ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        int           sel;
        bit           valid;
        logic [N-1:0] rvalid;
        int           rsel;
        bit           locked;
    } vec_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [N-1:0] host_req_i = '0, host_lock_i = '0;
    logic [N-1:0] host_gnt_o, host_rvalid_o;
    logic [1:0]   host_sel_o, resp_sel_o;
    logic         gnt_valid_o, locked_o;

    int checks = 0;
    int errors = 0;

    int m_last, m_cnt, m_rsel, e_sel;
    bit m_busy, m_locked, m_rv, e_valid, e_hold;

    vec_t base_t[11];
    vec_t lock_t[12];
    vec_t rv;

    always #5 clk_i = ~clk_i;

    bus_host_arbiter #(.NrHosts(N), .MaxLock(ML)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .host_req_i(host_req_i), .host_lock_i(host_lock_i),
        .host_gnt_o(host_gnt_o), .host_sel_o(host_sel_o), .gnt_valid_o(gnt_valid_o),
        .host_rvalid_o(host_rvalid_o), .resp_sel_o(resp_sel_o), .locked_o(locked_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = N - 1; m_cnt = 0; m_rsel = 0;
        m_busy = 0; m_locked = 0; m_rv = 0;
    endtask

    // Owner keeps the bus while it asks, holds lock and has grants left; else rotate.
    task automatic model_eval(input logic [N-1:0] req, input logic [N-1:0] lock);
        e_hold  = m_locked && req[m_last] && lock[m_last] && (m_cnt < ML);
        e_valid = e_hold;
        e_sel   = m_last;
        if (!e_hold)
            for (int k = 1; k <= N; k++)
                if (!e_valid && req[(m_last + k) % N]) begin
                    e_valid = 1;
                    e_sel   = (m_last + k) % N;
                end
    endtask

    task automatic model_advance(input logic [N-1:0] lock);
        if (e_hold) m_cnt++;
        else if (LockEn && e_valid && m_busy && lock[e_sel]) begin m_locked = 1; m_cnt = 1; end
        else begin m_locked = 0; m_cnt = 0; end
        m_busy = e_valid;
        m_rv   = e_valid;
        m_rsel = e_sel;
        if (e_valid) m_last = e_sel;
    endtask

    task automatic step(input vec_t v, input bit use_t);
        host_req_i  = v.req;
        host_lock_i = v.lock;
        #1;
        model_eval(v.req, v.lock);
        chk("gnt", host_gnt_o, e_valid ? (32'd1 << e_sel) : 32'd0);
        chk("sel", host_sel_o, e_sel);
        chk("gnt_valid", gnt_valid_o, e_valid);
        chk("rvalid", host_rvalid_o, m_rv ? (32'd1 << m_rsel) : 32'd0);
        chk("resp_sel", resp_sel_o, m_rsel);
        chk("locked", locked_o, m_locked);
        if (use_t) begin
            chk("tab_sel", host_sel_o, v.sel);
            chk("tab_gnt", host_gnt_o, v.valid ? (32'd1 << v.sel) : 32'd0);
            chk("tab_rvalid", host_rvalid_o, v.rvalid);
            chk("tab_resp_sel", resp_sel_o, v.rsel);
            chk("tab_locked", locked_o, v.locked);
        end
        @(posedge clk_i);
        model_advance(v.lock);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        host_req_i  = '0;
        host_lock_i = '0;
        rst_i       = 1'b1;
        #1;
        chk("rst_gnt", host_gnt_o, 0);
        chk("rst_valid", gnt_valid_o, 0);
        chk("rst_sel", host_sel_o, N - 1);
        chk("rst_rvalid", host_rvalid_o, 0);
        chk("rst_resp_sel", resp_sel_o, 0);
        chk("rst_locked", locked_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        base_t[0]  = '{3'b111, 3'b000, 0, 1, 3'b000, 0, 0};
        base_t[1]  = '{3'b111, 3'b000, 1, 1, 3'b001, 0, 0};
        base_t[2]  = '{3'b111, 3'b000, 2, 1, 3'b010, 1, 0};
        base_t[3]  = '{3'b111, 3'b000, 0, 1, 3'b100, 2, 0};
        base_t[4]  = '{3'b111, 3'b000, 1, 1, 3'b001, 0, 0};
        base_t[5]  = '{3'b111, 3'b000, 2, 1, 3'b010, 1, 0};
        base_t[6]  = '{3'b100, 3'b000, 2, 1, 3'b100, 2, 0};
        base_t[7]  = '{3'b101, 3'b000, 0, 1, 3'b100, 2, 0};
        base_t[8]  = '{3'b000, 3'b000, 0, 0, 3'b001, 0, 0};
        base_t[9]  = '{3'b000, 3'b000, 0, 0, 3'b000, 0, 0};
        base_t[10] = '{3'b000, 3'b000, 0, 0, 3'b000, 0, 0};

        lock_t[0]  = '{3'b001, 3'b000, 0, 1, 3'b000, 0, 0};
        lock_t[1]  = '{3'b011, 3'b010, 1, 1, 3'b001, 0, 0};
        lock_t[2]  = '{3'b011, 3'b010, 1, 1, 3'b010, 1, 1};
        lock_t[3]  = '{3'b011, 3'b010, 1, 1, 3'b010, 1, 1};
        lock_t[4]  = '{3'b011, 3'b010, 1, 1, 3'b010, 1, 1};
        lock_t[5]  = '{3'b011, 3'b010, 0, 1, 3'b010, 1, 1};
        lock_t[6]  = '{3'b011, 3'b010, 1, 1, 3'b001, 0, 0};
        lock_t[7]  = '{3'b011, 3'b010, 1, 1, 3'b010, 1, 1};
        lock_t[8]  = '{3'b011, 3'b000, 0, 1, 3'b010, 1, 1};
        lock_t[9]  = '{3'b011, 3'b000, 1, 1, 3'b001, 0, 0};
        lock_t[10] = '{3'b010, 3'b010, 1, 1, 3'b010, 1, 0};
        lock_t[11] = '{3'b010, 3'b010, 1, 1, 3'b010, 1, 1};

        #1;
        do_reset();
        for (int i = 0; i < 11; i++) step(base_t[i], 1'b1);

`ifdef BUS_ARB_LOCK_EN
        do_reset();
        for (int i = 0; i < 12; i++) step(lock_t[i], 1'b1);
        // Reset while host 1 still owns the bus.
        host_req_i  = 3'b010;
        host_lock_i = 3'b010;
        #1;
        chk("pre_rst_locked", locked_o, 1);
        chk("pre_rst_rvalid", host_rvalid_o, 3'b010);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_locked", locked_o, 0);
        chk("mid_rst_rvalid", host_rvalid_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        step('{3'b111, 3'b000, 0, 1, 3'b000, 0, 0}, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) do_reset();
            rv.req  = N'($urandom_range(0, 7));
            rv.lock = ($urandom_range(0, 3) != 0) ? N'($urandom_range(0, 7)) : '0;
            if ($urandom_range(0, 9) == 0) rv.req = '0;
            step(rv, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
